// File: rtl/ahb_arbiter_slave_1_pkg.sv
// Shared AHB encodings and arbiter state for the slave_1 arbiter.
package ahb_arbiter_slave_1_pkg;

  typedef enum logic [1:0] {
    TR_IDLE   = 2'b00,
    TR_BUSY   = 2'b01,
    TR_NONSEQ = 2'b10,
    TR_SEQ    = 2'b11
  } htrans_t;

  typedef enum logic [2:0] {
    HB_SINGLE = 3'b000,
    HB_INCR   = 3'b001,
    HB_WRAP4  = 3'b010,
    HB_INCR4  = 3'b011,
    HB_WRAP8  = 3'b100,
    HB_INCR8  = 3'b101,
    HB_WRAP16 = 3'b110,
    HB_INCR16 = 3'b111
  } hburst_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_GRANTED,
    ST_BURST,
    ST_INCR_BURST
  } arb_state_t;

  localparam int BEAT_CNT_W = 4;

  // Fixed-length beat count; SINGLE and undefined-length INCR report 1.
  function automatic logic [4:0] burst_beats(input hburst_t hb);
    case (hb)
      HB_WRAP4,  HB_INCR4:  burst_beats = 5'd4;
      HB_WRAP8,  HB_INCR8:  burst_beats = 5'd8;
      HB_WRAP16, HB_INCR16: burst_beats = 5'd16;
      default:              burst_beats = 5'd1;
    endcase
  endfunction

endpackage

// File: rtl/ahb_arbiter_slave_1_picker.sv
// Rotating priority picker: first set req bit at or after 'start' wins (one-hot).
module ahb_arb_picker #(
  parameter int N     = 3,
  parameter int IDX_W = 2
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] start,
  output logic [N-1:0]     grant
);

  logic [N-1:0] rot, rot_g;

  // Rotate so 'start' sits at bit 0, isolate the lowest set bit, rotate back.
  assign rot   = N'({req, req} >> start);
  assign rot_g = rot & (~rot + N'(1));
  assign grant = N'(({rot_g, rot_g} << start) >> N);

endmodule

// File: rtl/ahb_arbiter_slave_1.sv
// Per-slave AHB arbiter for slave_1: burst/lock-aware re-arbitration.
// Define AHB_ARB_RR_EN for round-robin; otherwise fixed priority (lowest index).
module ahb_arbiter_slave_1
  import ahb_arbiter_slave_1_pkg::*;
#(
  parameter int CHANNEL_NUM = 3,
  parameter int IDX_W       = (CHANNEL_NUM > 1) ? $clog2(CHANNEL_NUM) : 1
) (
  input  logic                   HCLK,
  input  logic                   HRESETn,
  input  logic [CHANNEL_NUM-1:0] hreq,
  input  logic [CHANNEL_NUM-1:0] hmastlock,
  input  logic [1:0]             htrans_g,
  input  logic [2:0]             hburst_g,
  input  logic                   hready,
  output logic [CHANNEL_NUM-1:0] addr_sel,
  output logic [CHANNEL_NUM-1:0] data_sel,
  output logic [IDX_W-1:0]       hmaster,
  output logic                   hmastlock_out
);

  arb_state_t              state, state_nxt;
  logic [BEAT_CNT_W-1:0]   beat_cnt, cnt_nxt;
  logic [CHANNEL_NUM-1:0]  winner;
  logic [IDX_W-1:0]        start_ptr;
  logic                    accept, arb_pt, start_ns;
  htrans_t                 ht;
  hburst_t                 hb;

  function automatic logic [IDX_W-1:0] enc(input logic [CHANNEL_NUM-1:0] v);
    enc = '0;
    for (int i = 0; i < CHANNEL_NUM; i++)
      if (v == (CHANNEL_NUM'(1) << i)) enc = IDX_W'(i);
  endfunction

  assign ht = htrans_t'(htrans_g);
  assign hb = hburst_t'(hburst_g);

`ifdef AHB_ARB_RR_EN
  logic [IDX_W-1:0] rr_ptr, win_idx;
  assign start_ptr = rr_ptr;
  assign win_idx   = enc(winner);
`else
  assign start_ptr = '0;
`endif

  ahb_arb_picker #(.N(CHANNEL_NUM), .IDX_W(IDX_W)) u_picker (
    .req   (hreq),
    .start (start_ptr),
    .grant (winner)
  );

  assign accept        = hready & (|addr_sel) & (ht == TR_NONSEQ || ht == TR_SEQ);
  assign hmaster       = enc(addr_sel);
  assign hmastlock_out = |(hmastlock & addr_sel);

  // Transfer-boundary detection; arb_pt marks where the grant may move.
  always_comb begin
    arb_pt    = 1'b0;
    start_ns  = 1'b0;
    state_nxt = state;
    cnt_nxt   = beat_cnt;
    case (state)
      ST_IDLE: arb_pt = 1'b1;
      ST_GRANTED: begin
        if (ht == TR_NONSEQ)    start_ns = 1'b1;
        else if (ht == TR_IDLE) arb_pt   = 1'b1;
      end
      ST_BURST: begin
        case (ht)
          TR_SEQ: begin
            if (beat_cnt == BEAT_CNT_W'(1)) arb_pt  = 1'b1;
            else                            cnt_nxt = beat_cnt - BEAT_CNT_W'(1);
          end
          TR_IDLE:   arb_pt   = 1'b1;
          TR_NONSEQ: start_ns = 1'b1;
          default: ;
        endcase
      end
      ST_INCR_BURST: begin
        if (ht == TR_IDLE)                         arb_pt   = 1'b1;
        else if (ht == TR_NONSEQ && hb != HB_INCR) start_ns = 1'b1;
      end
      default: ;
    endcase
    if (start_ns) begin
      if (hb == HB_SINGLE) arb_pt = 1'b1;
      else if (hb == HB_INCR) begin
        state_nxt = ST_INCR_BURST;
        cnt_nxt   = '0;
      end else begin
        state_nxt = ST_BURST;
        cnt_nxt   = BEAT_CNT_W'(burst_beats(hb) - 5'd1);
      end
    end
  end

  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      state    <= ST_IDLE;
      beat_cnt <= '0;
      addr_sel <= '0;
      data_sel <= '0;
`ifdef AHB_ARB_RR_EN
      rr_ptr   <= '0;
`endif
    end else if (hready) begin
      data_sel <= accept ? addr_sel : '0;
      state    <= state_nxt;
      beat_cnt <= cnt_nxt;
      if (arb_pt) begin
        beat_cnt <= '0;
        if (hmastlock_out) begin
          state <= ST_GRANTED;
        end else if (|hreq) begin
          addr_sel <= winner;
          state    <= ST_GRANTED;
`ifdef AHB_ARB_RR_EN
          rr_ptr   <= (win_idx == IDX_W'(CHANNEL_NUM - 1)) ? '0 : win_idx + IDX_W'(1);
`endif
        end else begin
          addr_sel <= '0;
          state    <= ST_IDLE;
        end
      end
    end
  end

endmodule
